frogger_game_fsm: RTL
=====================

// Module: frogger_game_fsm
// PURPOSE
// Top-level game sequencer for frogger_game: owns lives and level, freezes car traffic
// between rounds and issues frog respawn pulses. Consumes collision and frog position from
// the playfield datapath. Drives level into car speed and the score display.
// PARAMETERS
// START_LIVES     3    lives loaded at game start (1..3)
// HIT_FRAMES      60   frames frozen after a collision (1..255)
// LEVELUP_FRAMES  30   frames frozen after reaching goal row (1..255)
// MAX_LEVEL       99   level saturation value (fits 7 bits)
// GOAL_ROW        0    frog tile row that completes a crossing
// PORTS
// i_Clk          in   1  system clock (pixel clock domain)
// i_Rst          in   1  asynchronous, active-high reset
// i_Frame_Tick   in   1  one-cycle pulse per video frame (VSync edge)
// i_Game_Start   in   1  debounced start request, one-cycle pulse
// i_Collided     in   1  frog/car overlap, registered, level-valid
// i_Frog_Y       in   6  current frog tile row
// o_Game_Active  out  1  1 only in PLAY; gates frog movement
// o_Cars_Freeze  out  1  1 in every state except PLAY
// o_Frog_Reset   out  1  one-cycle pulse: return frog to start tile
// o_Lives        out  2  remaining lives
// o_Level        out  7  current level (score)
// o_Game_Over    out  1  1 in GAME_OVER
// o_Hit_Flash    out  1  timer bit 3 while in HIT, else 0 (LED blink)
// o_State        out  3  encoded state, debug
// BEHAVIOUR
// - States/encoding: IDLE=0, PLAY=1, HIT=2, LEVEL_UP=3, GAME_OVER=4; all outputs registered.
// - Reset (async, i_Rst=1): state IDLE, lives 0, level 0, timer 0, o_Frog_Reset 0,
//   o_Game_Active 0, o_Cars_Freeze 1, o_Game_Over 0, o_Hit_Flash 0.
// - IDLE/GAME_OVER + i_Game_Start: next cycle PLAY, lives=START_LIVES, level=0, o_Frog_Reset=1
//   for exactly that cycle. i_Game_Start ignored in PLAY, HIT, LEVEL_UP.
// - PLAY: i_Collided=1 -> HIT, lives decremented in same edge (never wraps below 0), timer=0.
//   Else i_Frog_Y==GOAL_ROW -> LEVEL_UP, level+1 saturating at MAX_LEVEL, timer=0.
//   Collision and goal in same cycle: collision wins, level unchanged.
// - HIT: timer +1 per i_Frame_Tick; i_Collided ignored. On tick that brings timer to
//   HIT_FRAMES: lives==0 -> GAME_OVER; else PLAY with o_Frog_Reset pulse (1 cycle).
// - LEVEL_UP: same timing with LEVELUP_FRAMES; exits to PLAY with o_Frog_Reset pulse.
// - Latency: input sampled on edge N, state/outputs valid after edge N (1 cycle).
// - Timer 8 bits, cleared on every state entry; ticks outside HIT/LEVEL_UP ignored.
// - Reset mid-round: immediate return to IDLE; no o_Frog_Reset emitted by reset itself.
// CONFIGURATION
// FROGGER_FSM_BONUS_LIFE_EN defined: on LEVEL_UP entry where new level is a nonzero
//   multiple of 5, lives +1 saturating at 3 (same edge as level increment).
// Undefined: lives change only by start load and collision decrement.
// TESTING
// 1 reset mid-PLAY -> o_State=0, o_Lives=0, o_Level=0, o_Cars_Freeze=1 without clock edge.
// 2 start pulse in IDLE -> next cycle o_State=1, o_Lives=3, one-cycle o_Frog_Reset, freeze=0.
// 3 collide in PLAY -> o_Lives 3->2, HIT for 60 ticks, then PLAY + o_Frog_Reset; flash toggles.
// 4 i_Frog_Y=0 and i_Collided same cycle -> HIT, o_Level unchanged, o_Lives decremented.
// 5 three collisions from 3 lives -> GAME_OVER after 3rd HIT, o_Game_Over=1; start restarts.
// 6 reach goal 100 times (fast params) -> o_Level stays 99; with BONUS_LIFE_EN, lives 2->3 at level 5.

Source files
------------

// File: rtl/frogger_game_fsm.sv
// -----------------------------------------------------------------------------
// frogger_game_fsm
// Top-level game sequencer for frogger_game. Owns the lives counter and the
// level (score), freezes car traffic between rounds and issues one-cycle frog
// respawn pulses. Every output is driven straight from a flop.
//
// Ports
//   i_Clk          system clock (pixel clock domain)
//   i_Rst          asynchronous, active-high reset
//   i_Frame_Tick   one-cycle pulse per video frame
//   i_Game_Start   debounced start request, one-cycle pulse
//   i_Collided     frog/car overlap, level-valid
//   i_Frog_Y[5:0]  current frog tile row
//   o_Game_Active  1 only in PLAY (gates frog movement)
//   o_Cars_Freeze  1 in every state except PLAY
//   o_Frog_Reset   one-cycle pulse: return frog to its start tile
//   o_Lives[1:0]   remaining lives
//   o_Level[6:0]   current level (score)
//   o_Game_Over    1 in GAME_OVER
//   o_Hit_Flash    timer bit 3 while in HIT, else 0
//   o_State[2:0]   encoded state (debug)
//
// Build option
//   FROGGER_FSM_BONUS_LIFE_EN : when defined, entering LEVEL_UP with a new
//   level that is a nonzero multiple of 5 grants one extra life (max 3).
// -----------------------------------------------------------------------------
module frogger_game_fsm #(
    parameter int START_LIVES    = 3,
    parameter int HIT_FRAMES     = 60,
    parameter int LEVELUP_FRAMES = 30,
    parameter int MAX_LEVEL      = 99,
    parameter int GOAL_ROW       = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Frame_Tick,
    input  logic       i_Game_Start,
    input  logic       i_Collided,
    input  logic [5:0] i_Frog_Y,
    output logic       o_Game_Active,
    output logic       o_Cars_Freeze,
    output logic       o_Frog_Reset,
    output logic [1:0] o_Lives,
    output logic [6:0] o_Level,
    output logic       o_Game_Over,
    output logic       o_Hit_Flash,
    output logic [2:0] o_State
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] START_LIVES_C = 2'(START_LIVES);
    localparam logic [7:0] HIT_LIM       = 8'(HIT_FRAMES);
    localparam logic [7:0] LVL_LIM       = 8'(LEVELUP_FRAMES);
    localparam logic [6:0] MAX_LEVEL_C   = 7'(MAX_LEVEL);
    localparam logic [5:0] GOAL_ROW_C    = 6'(GOAL_ROW);

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [6:0] level_q, level_d;
    logic [7:0] timer_q, timer_d;
    logic       frog_reset_q, frog_reset_d;
    logic       game_active_q, game_active_d;
    logic       cars_freeze_q, cars_freeze_d;
    logic       game_over_q, game_over_d;
    logic       hit_flash_q, hit_flash_d;

    logic [7:0] timer_inc_s;
    logic [6:0] level_inc_s;
    logic [1:0] lives_goal_s;

    // Lives after a collision; a round never starts with 0 lives, but keep it from wrapping.
    function automatic logic [1:0] lives_dec(input logic [1:0] lives);
        return (lives == 2'd0) ? 2'd0 : lives - 2'd1;
    endfunction

    // Shared increments used by the next-state logic.
    always_comb begin
        timer_inc_s = timer_q + 8'd1;
        level_inc_s = (level_q >= MAX_LEVEL_C) ? MAX_LEVEL_C : level_q + 7'd1;
    end

    // Lives value applied when a crossing completes (optional bonus life).
    always_comb begin
        lives_goal_s = lives_q;
`ifdef FROGGER_FSM_BONUS_LIFE_EN
        // Only a real level change earns the bonus, so a saturated level cannot farm lives.
        if ((level_inc_s != level_q) && (level_inc_s != 7'd0) &&
            ((level_inc_s % 7'd5) == 7'd0) && (lives_q != 2'd3)) begin
            lives_goal_s = lives_q + 2'd1;
        end else begin
            lives_goal_s = lives_q;
        end
`else
        lives_goal_s = lives_q;
`endif
    end

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        level_d      = level_q;
        timer_d      = timer_q;
        frog_reset_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (i_Game_Start) begin
                    state_d      = ST_PLAY;
                    lives_d      = START_LIVES_C;
                    level_d      = 7'd0;
                    timer_d      = 8'd0;
                    frog_reset_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PLAY: begin
                // Collision takes priority over reaching the goal row.
                if (i_Collided) begin
                    state_d = ST_HIT;
                    lives_d = lives_dec(lives_q);
                    timer_d = 8'd0;
                end else if (i_Frog_Y == GOAL_ROW_C) begin
                    state_d = ST_LEVEL_UP;
                    level_d = level_inc_s;
                    lives_d = lives_goal_s;
                    timer_d = 8'd0;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (i_Frame_Tick) begin
                    if (timer_inc_s == HIT_LIM) begin
                        timer_d = 8'd0;
                        if (lives_q == 2'd0) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d      = ST_PLAY;
                            frog_reset_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_inc_s;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_LEVEL_UP: begin
                if (i_Frame_Tick) begin
                    if (timer_inc_s == LVL_LIM) begin
                        timer_d      = 8'd0;
                        state_d      = ST_PLAY;
                        frog_reset_d = 1'b1;
                    end else begin
                        timer_d = timer_inc_s;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lives_d = 2'd0;
                level_d = 7'd0;
                timer_d = 8'd0;
            end
        endcase

        // Output flops are loaded from the next state so they line up with o_State.
        game_active_d = (state_d == ST_PLAY);
        cars_freeze_d = (state_d != ST_PLAY);
        game_over_d   = (state_d == ST_GAME_OVER);
        if (state_d == ST_HIT) begin
            hit_flash_d = timer_d[3];
        end else begin
            hit_flash_d = 1'b0;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q       <= ST_IDLE;
            lives_q       <= 2'd0;
            level_q       <= 7'd0;
            timer_q       <= 8'd0;
            frog_reset_q  <= 1'b0;
            game_active_q <= 1'b0;
            cars_freeze_q <= 1'b1;
            game_over_q   <= 1'b0;
            hit_flash_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            timer_q       <= timer_d;
            frog_reset_q  <= frog_reset_d;
            game_active_q <= game_active_d;
            cars_freeze_q <= cars_freeze_d;
            game_over_q   <= game_over_d;
            hit_flash_q   <= hit_flash_d;
        end
    end

    assign o_State       = state_q;
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;
    assign o_Frog_Reset  = frog_reset_q;
    assign o_Game_Active = game_active_q;
    assign o_Cars_Freeze = cars_freeze_q;
    assign o_Game_Over   = game_over_q;
    assign o_Hit_Flash   = hit_flash_q;

endmodule
